// File: rtl/response_transmitter.sv
// rtl/response_transmitter.sv - two-byte 8N1 response serializer with a one-entry pending buffer
module response_transmitter #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       finished,
    input  logic [7:0] response_code,
    input  logic [7:0] response,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic             byte_idx;
    logic [7:0]       act_code;
    logic [7:0]       act_value;
    logic             pend_valid;
    logic [7:0]       pend_code;
    logic [7:0]       pend_value;

    logic       bit_end;
    logic       frame_end;
    logic [7:0] cur_byte;

    assign bit_end   = (clk_cnt == CNT_LAST);
    assign frame_end = (state == STOP) && byte_idx && bit_end;
    assign cur_byte  = byte_idx ? act_value : act_code;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 1'b0;
            act_code   <= 8'd0;
            act_value  <= 8'd0;
            pend_valid <= 1'b0;
            pend_code  <= 8'd0;
            pend_value <= 8'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Requests arriving mid-frame go to the pending slot; the frame-end
            // cycle is handled in STOP so pop and push can happen together.
            if ((state != IDLE) && finished && !frame_end) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_code  <= response_code;
                    pend_value <= response;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (finished) begin
                        act_code  <= response_code;
                        act_value <= response;
                        state     <= START;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        clk_cnt   <= '0;
                        bit_idx   <= 3'd0;
                        byte_idx  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= cur_byte[0];
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= 3'd0;
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end else if (pend_valid) begin
                            act_code   <= pend_code;
                            act_value  <= pend_value;
                            byte_idx   <= 1'b0;
                            state      <= START;
                            tx         <= 1'b0;
                            pend_valid <= finished;
                            if (finished) begin
                                pend_code  <= response_code;
                                pend_value <= response;
                            end
                        end else if (finished) begin
                            act_code  <= response_code;
                            act_value <= response;
                            byte_idx  <= 1'b0;
                            state     <= START;
                            tx        <= 1'b0;
                        end else begin
                            byte_idx <= 1'b0;
                            state    <= IDLE;
                            tx       <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_response_transmitter.sv
// tb/tb_response_transmitter.sv - randomized bench with a per-cycle line-schedule model
module tb_response_transmitter;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       finished = 1'b0;
    logic [7:0] response_code = 8'd0;
    logic [7:0] response = 8'd0;
    logic       tx;
    logic       busy;
    logic       overrun;

    int ntests = 0;
    int nfail = 0;
    int ov_seen = 0;

    response_transmitter #(.CLOCK_FREQ(40), .BAUD_RATE(10)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .finished(finished),
        .response_code(response_code),
        .response(response),
        .tx(tx),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Model: a queue holding the tx level of every future line cycle, plus one pending slot.
    bit       mq[$];
    bit       pv = 1'b0;
    bit [7:0] pc = 8'd0;
    bit [7:0] pval = 8'd0;
    bit       exp_ov = 1'b0;

    task automatic push_frame(input bit [7:0] c, input bit [7:0] v);
        bit [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? c : v;
            for (int i = 0; i < 10; i++)
                for (int j = 0; j < CPB; j++)
                    mq.push_back((i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1]);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    initial begin
        bit       f;
        bit [7:0] c;
        bit [7:0] v;
        bit       etx;
        bit       ebusy;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                pv = 1'b0;
                exp_ov = 1'b0;
            end else begin
                f = finished;
                c = response_code;
                v = response;
                exp_ov = 1'b0;
                if (mq.size() > 0) void'(mq.pop_front());
                if (f) begin
                    if (mq.size() == 0) begin
                        if (pv) begin
                            push_frame(pc, pval);
                            pc = c;
                            pval = v;
                        end else begin
                            push_frame(c, v);
                        end
                    end else if (!pv) begin
                        pv = 1'b1;
                        pc = c;
                        pval = v;
                    end else begin
                        exp_ov = 1'b1;
                    end
                end else if (mq.size() == 0 && pv) begin
                    push_frame(pc, pval);
                    pv = 1'b0;
                end
                #1;
                if (reset_n) begin
                    etx = (mq.size() > 0) ? mq[0] : 1'b1;
                    ebusy = (mq.size() > 0);
                    ntests++;
                    if (tx !== etx || busy !== ebusy || overrun !== exp_ov) begin
                        nfail++;
                        $display("FAIL cycle t=%0t tx=%b/%b busy=%b/%b overrun=%b/%b (got/expected)",
                                 $time, tx, etx, busy, ebusy, overrun, exp_ov);
                    end
                    if (overrun === 1'b1) ov_seen++;
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            response_code = 8'($urandom);
            response = 8'($urandom);
        end
    endtask

    task automatic pulse(input bit [7:0] c, input bit [7:0] v);
        finished = 1'b1;
        response_code = c;
        response = v;
        @(negedge clock);
        finished = 1'b0;
        response_code = 8'($urandom);
        response = 8'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        if (n >= 1000) begin
            ntests++;
            nfail++;
            $display("FAIL wait_idle: busy still high after %0d cycles, expected low", n);
        end
    endtask

    initial begin
        bit exp_seq [20] = '{0,1,1,0,0,1,0,0,0,1, 0,1,0,0,1,1,0,0,0,1};
        int n;
        int bcnt;
        int hold;

        @(negedge clock);
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clock);

        // Basic frame, issued on the first edge after reset release.
        reset_n = 1'b1;
        pulse(8'h13, 8'h19);
        bcnt = 0;
        for (int i = 0; i < 20 * CPB; i++) begin
            if (i % CPB == 2) check($sformatf("basic_bit%0d", i / CPB), tx, exp_seq[i / CPB]);
            if (busy === 1'b1) bcnt++;
            @(negedge clock);
        end
        check("basic_busy_len", bcnt, 80);
        check("basic_busy_after", busy, 0);
        idle_cycles(5);

        // Back-to-back frames.
        ov_seen = 0;
        pulse(8'h14, 8'h32);
        idle_cycles(9);
        pulse(8'h10, 8'h11);
        wait_idle(n);
        check("b2b_busy_len", n + 10, 160);
        check("b2b_overrun", ov_seen, 0);
        idle_cycles(3);

        // Overflow: third request dropped.
        ov_seen = 0;
        pulse(8'hA1, 8'hA2);
        idle_cycles(5);
        pulse(8'hB1, 8'hB2);
        idle_cycles(5);
        pulse(8'hC1, 8'hC2);
        wait_idle(n);
        check("ovf_busy_len", n + 12, 160);
        check("ovf_overrun", ov_seen, 1);
        idle_cycles(3);

        // Request on the last stop cycle, pending empty.
        ov_seen = 0;
        pulse(8'h55, 8'hAA);
        idle_cycles(79);
        pulse(8'h0F, 8'hF0);
        wait_idle(n);
        check("edge_busy_len", n + 80, 160);
        check("edge_overrun", ov_seen, 0);
        idle_cycles(3);

        // Request on the last stop cycle, pending full.
        ov_seen = 0;
        pulse(8'h01, 8'h02);
        idle_cycles(10);
        pulse(8'h03, 8'h04);
        idle_cycles(68);
        pulse(8'h05, 8'h06);
        wait_idle(n);
        check("edgefull_busy_len", n + 80, 240);
        check("edgefull_overrun", ov_seen, 0);
        idle_cycles(3);

        // Reset mid-frame during a low data bit of byte 1, with a frame pending.
        pulse(8'h00, 8'h00);
        idle_cycles(3);
        pulse(8'h77, 8'h77);
        idle_cycles(8);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulse(8'hEC, 8'hEC);
        wait_idle(n);
        check("rst_clean_len", n, 80);
        idle_cycles(3);

        // Random traffic, including held-high finished.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold > 0) begin
                finished = 1'b1;
                hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                finished = 1'b1;
                hold = $urandom_range(0, 2);
            end else begin
                finished = 1'b0;
            end
            response_code = 8'($urandom);
            response = 8'($urandom);
            @(negedge clock);
        end
        finished = 1'b0;
        wait_idle(n);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
